// File: rtl/dsa_result_streamer.sv
// dsa_result_streamer
//
// Drains the interpolated output image from the upper half of the shared DSA
// memory after a run and presents it as a valid/ready byte stream. A running
// 16-bit checksum and a byte counter are kept for host-side verification.
//
// Ports:
//   clk, rst            sole clock (rising edge), asynchronous active-high reset
//   start               one-cycle drain request, ignored unless idle
//   img_width_out/_height_out  output image dimensions, sampled on accepted start
//   mem_read_en/mem_addr       read strobe and address to the external memory port
//   mem_data            read data, valid exactly one cycle after mem_read_en
//   out_valid/out_data/out_last/out_ready  byte stream with handshake
//   busy                high while streaming
//   done                one-cycle pulse after the final handshake
//   checksum            sum of streamed bytes modulo 2^16
//   bytes_sent          handshakes completed in the current run
module dsa_result_streamer #(
    parameter int unsigned ADDR_WIDTH = 18,
    parameter int unsigned BASE_ADDR  = 131072
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [15:0]           img_width_out,
    input  logic [15:0]           img_height_out,
    output logic                  mem_read_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [7:0]            mem_data,
    output logic                  out_valid,
    output logic [7:0]            out_data,
    output logic                  out_last,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           checksum,
    output logic [31:0]           bytes_sent
);

    localparam logic [ADDR_WIDTH-1:0] BaseAddr = ADDR_WIDTH'(BASE_ADDR);

    typedef enum logic [1:0] {
        StIdle,
        StStream,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [31:0]     total_q, total_d;
    logic [31:0]     issued_q, issued_d;
    logic            inflight_q, inflight_d;
    logic [1:0][7:0] fifo_mem_q, fifo_mem_d;
    logic            wr_ptr_q, wr_ptr_d;
    logic            rd_ptr_q, rd_ptr_d;
    logic [1:0]      fifo_count_q, fifo_count_d;
    logic [15:0]     checksum_q, checksum_d;
    logic [31:0]     bytes_sent_q, bytes_sent_d;

    logic            pop;
    logic [2:0]      occupancy;
    logic [31:0]     dims_product;

    assign dims_product = 32'(img_width_out) * 32'(img_height_out);

    // Stream side: the FIFO head is the byte with index bytes_sent_q.
    always_comb begin
        out_valid = (fifo_count_q != 2'd0);
        out_data  = out_valid ? fifo_mem_q[rd_ptr_q] : 8'h00;
        out_last  = out_valid && (bytes_sent_q == total_q - 32'd1);
        pop       = out_valid && out_ready;
    end

    // Read side: a same-cycle pop frees a slot, so reads keep pace with a
    // consumer that is always ready, while buffered + in-flight never exceeds 2.
    always_comb begin
        occupancy   = {1'b0, fifo_count_q} + {2'b00, inflight_q} - {2'b00, pop};
        mem_read_en = (state_q == StStream) && (issued_q < total_q) && (occupancy < 3'd2);
        mem_addr    = mem_read_en ? (BaseAddr + ADDR_WIDTH'(issued_q)) : '0;
    end

    always_comb begin
        state_d      = state_q;
        total_d      = total_q;
        issued_d     = issued_q;
        inflight_d   = mem_read_en;
        fifo_mem_d   = fifo_mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        fifo_count_d = fifo_count_q + {1'b0, inflight_q} - {1'b0, pop};
        checksum_d   = checksum_q;
        bytes_sent_d = bytes_sent_q;

        // Read data returns the cycle after issue and goes straight into the FIFO.
        if (inflight_q) begin
            fifo_mem_d[wr_ptr_q] = mem_data;
            wr_ptr_d             = ~wr_ptr_q;
        end

        if (pop) begin
            rd_ptr_d     = ~rd_ptr_q;
            bytes_sent_d = bytes_sent_q + 32'd1;
            checksum_d   = checksum_q + {8'h00, out_data};
        end

        if (mem_read_en) begin
            issued_d = issued_q + 32'd1;
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    total_d      = dims_product;
                    issued_d     = 32'd0;
                    checksum_d   = 16'd0;
                    bytes_sent_d = 32'd0;
                    // An empty image has nothing to read; report completion directly.
                    state_d      = (dims_product == 32'd0) ? StDone : StStream;
                end
            end
            StStream: begin
                if (pop && out_last) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            total_q      <= 32'd0;
            issued_q     <= 32'd0;
            inflight_q   <= 1'b0;
            fifo_mem_q   <= '0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            fifo_count_q <= 2'd0;
            checksum_q   <= 16'd0;
            bytes_sent_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            total_q      <= total_d;
            issued_q     <= issued_d;
            inflight_q   <= inflight_d;
            fifo_mem_q   <= fifo_mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fifo_count_q <= fifo_count_d;
            checksum_q   <= checksum_d;
            bytes_sent_q <= bytes_sent_d;
        end
    end

    assign busy       = (state_q == StStream);
    assign done       = (state_q == StDone);
    assign checksum   = checksum_q;
    assign bytes_sent = bytes_sent_q;

    // Returning data must always find a free slot.
    fifo_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(inflight_q && (fifo_count_q == 2'd2) && !pop));

endmodule

// File: tb/tb_dsa_result_streamer.sv
module tb_dsa_result_streamer;

    localparam int unsigned AW   = 18;
    localparam int unsigned BASE = 131072;
    localparam int          MEMW = 1 << AW;

    logic          clk;
    logic          rst;
    logic          start;
    logic [15:0]   img_width_out;
    logic [15:0]   img_height_out;
    logic          mem_read_en;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_data;
    logic          out_valid;
    logic [7:0]    out_data;
    logic          out_last;
    logic          out_ready;
    logic          busy;
    logic          done;
    logic [15:0]   checksum;
    logic [31:0]   bytes_sent;

    logic [7:0]    mem [0:MEMW-1];

    int checks;
    int errors;

    dsa_result_streamer #(
        .ADDR_WIDTH (AW),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .img_width_out  (img_width_out),
        .img_height_out (img_height_out),
        .mem_read_en    (mem_read_en),
        .mem_addr       (mem_addr),
        .mem_data       (mem_data),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .out_last       (out_last),
        .out_ready      (out_ready),
        .busy           (busy),
        .done           (done),
        .checksum       (checksum),
        .bytes_sent     (bytes_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: synchronous read, data valid the cycle after the strobe.
    always @(posedge clk) begin
        if (mem_read_en) mem_data <= mem[mem_addr];
    end

    typedef struct {
        int w;
        int h;
        int kind;      // fill pattern
        int rmode;     // 0: out_ready always 1, 1: ready on every third cycle
        int poke;      // cycle at which a second start (9x9) is pulsed, -1 none
        int exp_cnt;
        int exp_sum;
        int exp_done;  // expected done cycle, 0 = not checked
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [7:0] fill(input int kind, input int i);
        case (kind)
            0:       return 8'((i + 1) * 10);
            1:       return 8'(7 * i + 3);
            2:       return 8'hFF;
            default: return 8'(255 - 50 * i);
        endcase
    endfunction

    function automatic logic ready_at(input int rmode, input int c);
        return (rmode == 0) ? 1'b1 : ((c % 3) == 0);
    endfunction

    task automatic check_zero(input string tag);
        check({tag, "_ctrl"}, 64'({mem_read_en, out_valid, out_last, busy, done}), 64'd0);
        check({tag, "_addr"}, 64'(mem_addr), 64'd0);
        check({tag, "_data"}, 64'(out_data), 64'd0);
        check({tag, "_sum"}, 64'(checksum), 64'd0);
        check({tag, "_bytes"}, 64'(bytes_sent), 64'd0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int total;
        int c;
        int popped;
        int reads;
        int done_c;
        int limit;
        int last_addr;
        logic prev_stall;
        logic [7:0] prev_data;
        logic pop_now;
        total = v.w * v.h;
        for (int i = 0; i < total; i++) mem[(BASE + i) % MEMW] = fill(v.kind, i);
        mem[(BASE + total) % MEMW]     = 8'hEE;
        mem[(BASE + total + 1) % MEMW] = 8'hEE;
        limit      = total * 4 + 20;
        popped     = 0;
        reads      = 0;
        done_c     = -1;
        last_addr  = -1;
        prev_stall = 1'b0;
        prev_data  = 8'h00;

        @(negedge clk);
        c              = 0;
        start          = 1'b1;
        img_width_out  = 16'(v.w);
        img_height_out = 16'(v.h);
        out_ready      = ready_at(v.rmode, 0);
        #1;
        check($sformatf("v%0d_idle_busy", idx), 64'(busy), 64'd0);

        while (done_c < 0 && c < limit) begin
            @(negedge clk);
            c++;
            start = (c == v.poke);
            if (c == v.poke) begin
                img_width_out  = 16'd9;
                img_height_out = 16'd9;
            end
            out_ready = ready_at(v.rmode, c);
            #1;
            pop_now = out_valid && out_ready;
            if (mem_read_en) begin
                check($sformatf("v%0d_addr", idx), 64'(mem_addr), 64'((BASE + reads) % MEMW));
                check($sformatf("v%0d_read_bound", idx),
                      64'((reads < total) && (reads + 1 - popped - int'(pop_now) <= 2)), 64'd1);
                last_addr = int'(mem_addr);
                reads++;
            end
            if (out_valid) begin
                if (prev_stall)
                    check($sformatf("v%0d_stable", idx), 64'(out_data), 64'(prev_data));
                check($sformatf("v%0d_data", idx), 64'(out_data), 64'(fill(v.kind, popped)));
                check($sformatf("v%0d_last", idx), 64'(out_last), 64'(popped == total - 1));
                prev_stall = !out_ready;
                prev_data  = out_data;
                if (out_ready) popped++;
            end else begin
                prev_stall = 1'b0;
            end
            check($sformatf("v%0d_busy", idx), 64'(busy), 64'((total != 0) && !done));
            if (done) done_c = c;
        end

        if (done_c < 0) begin
            check($sformatf("v%0d_done_timeout", idx), 64'(done), 64'd1);
        end else begin
            check($sformatf("v%0d_popped", idx), 64'(popped), 64'(v.exp_cnt));
            check($sformatf("v%0d_reads", idx), 64'(reads), 64'(v.exp_cnt));
            check($sformatf("v%0d_checksum", idx), 64'(checksum), 64'(v.exp_sum));
            check($sformatf("v%0d_bytes_sent", idx), 64'(bytes_sent), 64'(v.exp_cnt));
            if (v.exp_done > 0)
                check($sformatf("v%0d_done_cycle", idx), 64'(done_c), 64'(v.exp_done));
            if (total > 0)
                check($sformatf("v%0d_final_addr", idx), 64'(last_addr),
                      64'((BASE + total - 1) % MEMW));
        end

        // Back in idle: done has dropped, results hold.
        @(negedge clk);
        #1;
        check($sformatf("v%0d_done_pulse", idx), 64'(done), 64'd0);
        check($sformatf("v%0d_hold_sum", idx), 64'(checksum), 64'(v.exp_sum));
        check($sformatf("v%0d_hold_bytes", idx), 64'(bytes_sent), 64'(v.exp_cnt));
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        rst            = 1'b1;
        start          = 1'b0;
        out_ready      = 1'b0;
        img_width_out  = 16'd0;
        img_height_out = 16'd0;

        //            w    h  kind rm poke cnt    sum  done
        vecs[0] = '{2,   2,   0, 0, -1, 4,     100, 7};
        vecs[1] = '{4,   3,   1, 1, -1, 12,    498, 0};
        vecs[2] = '{0,   5,   0, 0, -1, 0,     0,   1};
        vecs[3] = '{3,   1,   3, 0, -1, 3,     615, 6};
        vecs[4] = '{3,   2,   0, 0,  2, 6,     210, 9};
        vecs[5] = '{256, 256, 2, 0, -1, 65536, 0,   65539};

        repeat (2) @(negedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;

        for (int k = 0; k < 6; k++) run_vec(vecs[k], k);

        // Reset mid-run with one byte buffered and one read in flight.
        for (int i = 0; i < 12; i++) mem[BASE + i] = fill(1, i);
        @(negedge clk);
        start          = 1'b1;
        img_width_out  = 16'd4;
        img_height_out = 16'd3;
        out_ready      = 1'b0;
        @(negedge clk);
        start = 1'b0;
        #1;
        check("mr_c1_read", 64'({mem_read_en, mem_addr}), 64'({1'b1, AW'(BASE)}));
        @(negedge clk);
        #1;
        check("mr_c2_read", 64'({mem_read_en, mem_addr}), 64'({1'b1, AW'(BASE + 1)}));
        @(negedge clk);
        #1;
        check("mr_c3_valid", 64'(out_valid), 64'd1);
        check("mr_c3_head", 64'(out_data), 64'(fill(1, 0)));
        check("mr_c3_noread", 64'(mem_read_en), 64'd0);
        rst = 1'b1;
        #1;
        check_zero("mr_async");
        @(negedge clk);
        #1;
        check_zero("mr_held");
        rst = 1'b0;

        run_vec(vecs[0], 6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
